arbitro_mem: RTL and testbench
==============================

// Module: arbitro_mem
// PURPOSE
//  Arbiter/sequencer for the dual-port 128x32 data memory. Shares both memory ports among
//  4 requesters (fetch, load/store, 2 aux) with round-robin fairness. Blocks same-address
//  hazards. Clears memory to zero after reset (optional). Sits between the pipeline/DMA
//  clients and the mem block.
// PARAMETERS
//  AW       7   memory address width (128 words)
//  DW       32  data width
//  INIT_EN  1   1: zero-fill all 2**AW words after reset; 0: go straight to RUN
// PORTS
//  reloj      in   1      clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  req        in   4      request per client; held until gnt
//  we         in   4      1 = write, 0 = read (per client)
//  w_h        in   4      1 = full word, 0 = half word (write {16'b0,di[15:0]})
//  dir        in   4*AW   packed addresses, client i = dir[i*AW +: AW]
//  di         in   4*DW   packed write data, client i = di[i*DW +: DW]
//  gnt        out  4      request accepted this cycle (combinational)
//  rvalid     out  4      read data valid for client i (one cycle)
//  rdata      out  4*DW   packed read data, client i = rdata[i*DW +: DW]
//  busy       out  1      1 during reset/INIT; no grants while high
//  DIR_MEM1/2 out  AW     memory port addresses
//  DI_MEM1/2  out  DW     memory port write data
//  MEM_RD1/2  out  1      memory control (encoding below)
//  MEM_WR1/2  out  1      memory control, always 0
//  w_h1/2     out  1      memory half/full select
//  DO_MEMo1/2 in   DW     memory registered read data
// BEHAVIOUR
//  - Memory control encoding: write = MEM_RDx=1,MEM_WRx=0; read/idle = MEM_RDx=0,MEM_WRx=0.
//    Idle port: read encoding, DIR=0, DI=0, w_h=1.
//  - Reset (sync): gnt=0, rvalid=0, rdata=0, ptr=0, tags cleared, ports idle;
//    busy=INIT_EN. FSM -> INIT (INIT_EN=1) else RUN.
//  - FSM INIT: counter c=0..63; port1 writes addr 2c, port2 writes 2c+1, data 0, w_h=1.
//    After c=63 -> RUN (64 cycles). busy=1 throughout; gnt=0; req ignored, not lost (held).
//  - FSM RUN: busy=0. Each cycle scan clients in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//    First requester -> port1. Next requester not in hazard with it -> port2. Others wait.
//  - Hazard: same dir and (either we=1) -> later candidate skipped this cycle,
//    scan continues. Two reads of one address both granted.
//  - ptr update: if >=1 grant, ptr <= (index of last granted)+1 mod 4; else unchanged.
//  - gnt[i] asserted in same cycle T as memory drive. Write commits at edge ending T.
//  - Read latency 1: tag (client, port) registered at end of T. In T+1 rvalid[i]=1,
//    rdata[i]=DO_MEMo of that port; rdata of non-valid clients = 0.
//  - Read in T+1 of address written in T returns new data.
//  - Reset mid-INIT restarts fill at c=0. Reset in T+1 of a read drops that rvalid.
//  - Back-to-back: client may re-request in cycle after gnt; fully pipelined,
//    2 accesses/cycle max.
// TESTING
//  1 INIT_EN=1, reset 2 cycles -> busy=1 for exactly 64 cycles after release;
//    then read 0x7F and 0x00 -> rvalid, rdata=0.
//  2 client2 write 0xDEADBEEF @0x05 w_h=1, then read @0x05 -> gnt same cycle, rvalid[2]
//    next cycle = 0xDEADBEEF. Write 0x12345678 w_h=0 then read -> 0x00005678.
//  3 ptr=0, all 4 read distinct addrs -> cycle1 gnt=0011 (0->port1, 1->port2);
//    cycle2 gnt=1100; ptr back to 0.
//  4 client0 write 0xA5A5A5A5 @0x09, client1 read @0x09 same cycle -> gnt=0001 only.
//    Next cycle gnt[1]=1; rvalid[1] data=0xA5A5A5A5.
//  5 all 4 req held continuously 8 cycles -> each client granted exactly 4 times,
//    never 2 consecutive cycles skipped.
//  6 reset pulsed at INIT c=20 -> fill restarts; busy stays 1 for 64 cycles after release.
//    No gnt during busy despite req=1111.

Source files
------------

// File: rtl/arbitro_mem.sv
// Round-robin arbiter sharing the two ports of a 128x32 data memory among 4 clients, with optional zero-fill after reset.
// Latency: grants and port drive are combinational in cycle T; read data and rvalid appear in T+1.
// Backpressure: a client keeps req high until it sees gnt; busy (reset/fill) or a same-address hazard simply withholds gnt.
module arbitro_mem #(
    parameter int AW      = 7,
    parameter int DW      = 32,
    parameter int INIT_EN = 1
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [3:0]        we,
    input  logic [3:0]        w_h,
    input  logic [4*AW-1:0]   dir,
    input  logic [4*DW-1:0]   di,
    output logic [3:0]        gnt,
    output logic [3:0]        rvalid,
    output logic [4*DW-1:0]   rdata,
    output logic              busy,
    output logic [AW-1:0]     DIR_MEM1,
    output logic [AW-1:0]     DIR_MEM2,
    output logic [DW-1:0]     DI_MEM1,
    output logic [DW-1:0]     DI_MEM2,
    output logic              MEM_RD1,
    output logic              MEM_RD2,
    output logic              MEM_WR1,
    output logic              MEM_WR2,
    output logic              w_h1,
    output logic              w_h2,
    input  logic [DW-1:0]     DO_MEMo1,
    input  logic [DW-1:0]     DO_MEMo2
);

    localparam logic [0:0]    S_INIT  = 1'b0;
    localparam logic [0:0]    S_RUN   = 1'b1;
    localparam logic [AW-2:0] CNT_ONE = 1;

    logic [0:0]    state;
    logic [AW-2:0] cnt;        // fill counter: one address pair per cycle
    logic [1:0]    ptr;        // round-robin start point
    logic          t1_vld, t2_vld;
    logic [1:0]    t1_cli, t2_cli;

    logic [AW-1:0] dir_a  [4];
    logic [DW-1:0] di_eff [4];
    logic [DW-1:0] rdata_a[4];

    logic          p1_vld, p2_vld;
    logic [1:0]    p1, p2, idx;
    logic          run;

    // Unpack per-client fields; half-word writes carry only the low 16 bits.
    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign dir_a[i]             = dir[i*AW +: AW];
        assign di_eff[i]            = w_h[i] ? di[i*DW +: DW] : {{(DW-16){1'b0}}, di[i*DW +: 16]};
        assign rdata[i*DW +: DW]    = rdata_a[i];
    end

    assign run     = ~reset & (state == S_RUN);
    assign busy    = reset ? (INIT_EN != 0) : (state == S_INIT);
    assign MEM_WR1 = 1'b0;
    assign MEM_WR2 = 1'b0;

    // Round-robin scan: first requester takes port 1, next non-conflicting one takes port 2.
    always_comb begin
        p1_vld = 1'b0;
        p2_vld = 1'b0;
        p1     = '0;
        p2     = '0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                if (!p1_vld) begin
                    p1_vld = 1'b1;
                    p1     = idx;
                end else if (!p2_vld && !((dir_a[idx] == dir_a[p1]) && (we[idx] | we[p1]))) begin
                    p2_vld = 1'b1;
                    p2     = idx;
                end
            end
        end
    end

    // Grants are only visible while running and out of reset.
    always_comb begin
        gnt = '0;
        if (run) begin
            if (p1_vld) gnt[p1] = 1'b1;
            if (p2_vld) gnt[p2] = 1'b1;
        end
    end

    // Memory port drive: fill pattern during INIT, granted clients in RUN, idle otherwise.
    always_comb begin
        DIR_MEM1 = '0;  DI_MEM1 = '0;  MEM_RD1 = 1'b0;  w_h1 = 1'b1;
        DIR_MEM2 = '0;  DI_MEM2 = '0;  MEM_RD2 = 1'b0;  w_h2 = 1'b1;
        if (!reset && state == S_INIT) begin
            DIR_MEM1 = {cnt, 1'b0};
            DIR_MEM2 = {cnt, 1'b1};
            MEM_RD1  = 1'b1;
            MEM_RD2  = 1'b1;
        end else if (run) begin
            if (p1_vld) begin
                DIR_MEM1 = dir_a[p1];
                DI_MEM1  = we[p1] ? di_eff[p1] : '0;
                MEM_RD1  = we[p1];
                w_h1     = w_h[p1];
            end
            if (p2_vld) begin
                DIR_MEM2 = dir_a[p2];
                DI_MEM2  = we[p2] ? di_eff[p2] : '0;
                MEM_RD2  = we[p2];
                w_h2     = w_h[p2];
            end
        end
    end

    // Return read data to the client tagged last cycle; reset squashes in-flight reads.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < 4; i++) rdata_a[i] = '0;
        if (!reset) begin
            if (t1_vld) begin
                rvalid[t1_cli]  = 1'b1;
                rdata_a[t1_cli] = DO_MEMo1;
            end
            if (t2_vld) begin
                rvalid[t2_cli]  = 1'b1;
                rdata_a[t2_cli] = DO_MEMo2;
            end
        end
    end

    // FSM, fill counter, round-robin pointer and read tags.
    always_ff @(posedge reloj) begin
        if (reset) begin
            state  <= (INIT_EN != 0) ? S_INIT : S_RUN;
            cnt    <= '0;
            ptr    <= '0;
            t1_vld <= 1'b0;
            t2_vld <= 1'b0;
            t1_cli <= '0;
            t2_cli <= '0;
        end else begin
            t1_vld <= run & p1_vld & ~we[p1];
            t2_vld <= run & p2_vld & ~we[p2];
            t1_cli <= p1;
            t2_cli <= p2;
            if (state == S_INIT) begin
                cnt <= cnt + CNT_ONE;
                if (&cnt) state <= S_RUN;
            end else if (p1_vld) begin
                ptr <= (p2_vld ? p2 : p1) + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_mem.sv
// Directed bench for arbitro_mem with a behavioural dual-port memory behind it.
// Latency: checks grants in the request cycle and read data one cycle later.
// Backpressure: requests are held by the bench until granted, as a real client would.
module tb_arbitro_mem;

    logic          reloj = 1'b0;
    logic          reset;
    logic [3:0]    req, we, w_h;
    logic [27:0]   dir;
    logic [127:0]  di;
    logic [3:0]    gnt, rvalid;
    logic [127:0]  rdata;
    logic          busy;
    logic [6:0]    DIR_MEM1, DIR_MEM2;
    logic [31:0]   DI_MEM1, DI_MEM2;
    logic          MEM_RD1, MEM_RD2, MEM_WR1, MEM_WR2, w_h1, w_h2;
    logic [31:0]   DO_MEMo1, DO_MEMo2;

    logic [31:0]   mem [128];
    logic          seed;
    int            nvec = 0;
    int            nerr = 0;
    int            n;
    int            cnt_g [4];
    logic [3:0]    e, prev;

    arbitro_mem #(.AW(7), .DW(32), .INIT_EN(1)) dut (
        .reloj(reloj), .reset(reset), .req(req), .we(we), .w_h(w_h), .dir(dir), .di(di),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .DIR_MEM1(DIR_MEM1), .DIR_MEM2(DIR_MEM2), .DI_MEM1(DI_MEM1), .DI_MEM2(DI_MEM2),
        .MEM_RD1(MEM_RD1), .MEM_RD2(MEM_RD2), .MEM_WR1(MEM_WR1), .MEM_WR2(MEM_WR2),
        .w_h1(w_h1), .w_h2(w_h2), .DO_MEMo1(DO_MEMo1), .DO_MEMo2(DO_MEMo2)
    );

    always #5 reloj = ~reloj;

    // Memory model: registered reads, MEM_RD=1 means write; seeded with non-zero garbage.
    always @(posedge reloj) begin
        if (seed) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
        end else begin
            if (MEM_RD1) mem[DIR_MEM1] <= w_h1 ? DI_MEM1 : {16'h0, DI_MEM1[15:0]};
            if (MEM_RD2) mem[DIR_MEM2] <= w_h2 ? DI_MEM2 : {16'h0, DI_MEM2[15:0]};
        end
        DO_MEMo1 <= mem[DIR_MEM1];
        DO_MEMo2 <= mem[DIR_MEM2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cli(input int i, input logic r, input logic w, input logic h,
                           input logic [6:0] a, input logic [31:0] d);
        req[i] = r;
        we[i]  = w;
        w_h[i] = h;
        dir[i*7 +: 7]   = a;
        di[i*32 +: 32]  = d;
    endtask

    // Called right after reset is released at a negedge; counts busy cycles, bounded.
    task automatic run_init(input int stop_at, output int nb);
        nb = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!busy) break;
            check("init_gnt", 32'(gnt), 32'h0);
            if (nb == 5) begin
                check("init_dir1", 32'(DIR_MEM1), 32'd10);
                check("init_dir2", 32'(DIR_MEM2), 32'd11);
                check("init_wr1",  32'(MEM_RD1), 32'd1);
                check("init_wr2",  32'(MEM_RD2), 32'd1);
                check("init_di1",  DI_MEM1, 32'h0);
                check("init_wh1",  32'(w_h1), 32'd1);
            end
            nb++;
            if (nb == stop_at) return;
            @(negedge reloj);
        end
    endtask

    initial begin
        seed = 1'b1;
        reset = 1'b1; req = '0; we = '0; w_h = '1; dir = '0; di = '0;
        @(negedge reloj);
        seed = 1'b0;
        @(negedge reloj); #1;
        check("rst_busy",   32'(busy), 32'd1);
        check("rst_gnt",    32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rd1",    32'(MEM_RD1), 32'd0);
        check("rst_rd2",    32'(MEM_RD2), 32'd0);

        // 1: fill length, then zeroed extremes
        @(negedge reloj); reset = 1'b0;
        run_init(-1, n);
        check("t1_busy_len", 32'(n), 32'd64);
        set_cli(0, 1, 0, 1, 7'h7F, 0);
        set_cli(1, 1, 0, 1, 7'h00, 0);
        #1;
        check("t1_gnt",  32'(gnt), 32'b0011);
        check("t1_dir1", 32'(DIR_MEM1), 32'h7F);
        check("t1_dir2", 32'(DIR_MEM2), 32'h00);
        check("t1_rd1",  32'(MEM_RD1), 32'd0);
        @(negedge reloj); req = '0; #1;
        check("t1_rvalid", 32'(rvalid), 32'b0011);
        check("t1_rdata0", rdata[31:0], 32'h0);
        check("t1_rdata1", rdata[63:32], 32'h0);

        // 2: full and half word write then read (ptr=2)
        @(negedge reloj); set_cli(2, 1, 1, 1, 7'h05, 32'hDEADBEEF); #1;
        check("t2_gnt_w", 32'(gnt), 32'b0100);
        check("t2_wr1",   32'(MEM_RD1), 32'd1);
        check("t2_dir1",  32'(DIR_MEM1), 32'h05);
        check("t2_di1",   DI_MEM1, 32'hDEADBEEF);
        @(negedge reloj); set_cli(2, 1, 0, 1, 7'h05, 0); #1;
        check("t2_gnt_r", 32'(gnt), 32'b0100);
        check("t2_rd1",   32'(MEM_RD1), 32'd0);
        @(negedge reloj); set_cli(2, 1, 1, 0, 7'h05, 32'h12345678); #1;
        check("t2_rvalid", 32'(rvalid), 32'b0100);
        check("t2_rdata",  rdata[95:64], 32'hDEADBEEF);
        check("t2_other",  rdata[31:0], 32'h0);
        check("t2_gnt_hw", 32'(gnt), 32'b0100);
        check("t2_wh1",    32'(w_h1), 32'd0);
        @(negedge reloj); set_cli(2, 1, 0, 1, 7'h05, 0); #1;
        check("t2_gnt_r2", 32'(gnt), 32'b0100);
        @(negedge reloj); req = '0; #1;
        check("t2_rvalid2", 32'(rvalid), 32'b0100);
        check("t2_rdata_hw", rdata[95:64], 32'h00005678);

        // 4: write/read hazard on one address (ptr=3)
        @(negedge reloj);
        set_cli(0, 1, 1, 1, 7'h09, 32'hA5A5A5A5);
        set_cli(1, 1, 0, 1, 7'h09, 0);
        #1;
        check("t4_gnt", 32'(gnt), 32'b0001);
        @(negedge reloj); set_cli(0, 0, 0, 1, 0, 0); #1;
        check("t4_gnt2", 32'(gnt), 32'b0010);
        @(negedge reloj); req = '0; #1;
        check("t4_rvalid", 32'(rvalid), 32'b0010);
        check("t4_rdata",  rdata[63:32], 32'hA5A5A5A5);

        // two reads of the same address share a cycle (ptr=2)
        @(negedge reloj);
        set_cli(2, 1, 0, 1, 7'h05, 0);
        set_cli(3, 1, 0, 1, 7'h05, 0);
        #1;
        check("rr_gnt",  32'(gnt), 32'b1100);
        check("rr_dir2", 32'(DIR_MEM2), 32'h05);
        @(negedge reloj); req = '0; #1;
        check("rr_rvalid", 32'(rvalid), 32'b1100);
        check("rr_rdata2", rdata[95:64], 32'h00005678);
        check("rr_rdata3", rdata[127:96], 32'h00005678);

        // 3: four distinct reads (ptr=0)
        @(negedge reloj);
        set_cli(0, 1, 0, 1, 7'h05, 0);
        set_cli(1, 1, 0, 1, 7'h09, 0);
        set_cli(2, 1, 0, 1, 7'h7F, 0);
        set_cli(3, 1, 0, 1, 7'h00, 0);
        #1;
        check("t3_gnt1", 32'(gnt), 32'b0011);
        @(negedge reloj); set_cli(0, 0, 0, 1, 0, 0); set_cli(1, 0, 0, 1, 0, 0); #1;
        check("t3_gnt2",   32'(gnt), 32'b1100);
        check("t3_rvalid", 32'(rvalid), 32'b0011);
        check("t3_rdata0", rdata[31:0], 32'h00005678);
        check("t3_rdata1", rdata[63:32], 32'hA5A5A5A5);
        @(negedge reloj); req = '0; #1;
        check("t3_rvalid2", 32'(rvalid), 32'b1100);
        check("t3_rdata2",  rdata[95:64], 32'h0);
        check("t3_rdata3",  rdata[127:96], 32'h0);

        // 5: all four held for 8 cycles -> strict alternation
        for (int i = 0; i < 4; i++) cnt_g[i] = 0;
        prev = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge reloj);
            if (c == 0) req = 4'b1111;
            #1;
            e = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            check("t5_gnt", 32'(gnt), 32'(e));
            check("t5_rvalid", 32'(rvalid), 32'(prev));
            for (int i = 0; i < 4; i++) cnt_g[i] += int'(gnt[i]);
            prev = e;
        end
        for (int i = 0; i < 4; i++) check("t5_count", 32'(cnt_g[i]), 32'd4);

        // 6: reset right after a read drops rvalid; reset mid-fill restarts it
        @(negedge reloj); reset = 1'b1; #1;
        check("t6_rv_drop", 32'(rvalid), 32'h0);
        check("t6_rst_gnt", 32'(gnt), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'd1);
        @(negedge reloj); reset = 1'b0;
        run_init(20, n);
        check("t6_pre_len", 32'(n), 32'd20);
        @(negedge reloj); reset = 1'b1; #1;
        check("t6_mid_gnt", 32'(gnt), 32'h0);
        @(negedge reloj); reset = 1'b0;
        run_init(-1, n);
        check("t6_busy_len", 32'(n), 32'd64);
        #1;
        check("t6_gnt1", 32'(gnt), 32'b0011);
        @(negedge reloj); #1;
        check("t6_gnt2",   32'(gnt), 32'b1100);
        check("t6_rvalid", 32'(rvalid), 32'b0011);
        check("t6_rdata0", rdata[31:0], 32'h0);
        check("t6_rdata1", rdata[63:32], 32'h0);
        @(negedge reloj); req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
